// File: rtl/ft_pkg.sv
// Shared types, timing minimums and sizing helper for the FT2232H async-FIFO reader.
package ft_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STROBE = 2'd1,
        HOLD   = 2'd2
    } ft_state_e;

    localparam int unsigned FT_RD_LOW_MIN  = 2;
    localparam int unsigned FT_RD_HIGH_MIN = 3;

    // Occupancy counter width: must represent 0..depth inclusive.
    function automatic int unsigned ft_level_w(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/ft_rx_fifo.sv
// Synchronous first-word-fall-through FIFO with a registered head word.
// Caller must only assert pop while the FIFO is non-empty; drop_c flags a push lost to a full FIFO.
module ft_rx_fifo
    import ft_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          push,
    input  logic [DATA_W-1:0]             push_data,
    input  logic                          pop,
    output logic [DATA_W-1:0]             data_out,
    output logic                          valid,
    output logic [ft_level_w(DEPTH)-1:0]  level,
    output logic                          full_c,
    output logic                          empty_c,
    output logic                          drop_c
);

    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned LVL_W = ft_level_w(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]  level_q, level_d;
    logic [DATA_W-1:0] head_q, head_d;
    logic              valid_q, valid_d;
    logic              do_push_c;

    assign full_c    = (level_q == LVL_W'(DEPTH));
    assign empty_c   = (level_q == '0);
    assign do_push_c = push && (!full_c || pop);
    assign drop_c    = push && full_c && !pop;

    // Head register tracks the word at rd_ptr so m_data is a flop output.
    always_comb begin
        wr_ptr_d = wr_ptr_q + AW'(do_push_c);
        rd_ptr_d = rd_ptr_q + AW'(pop);
        level_d  = level_q + LVL_W'(do_push_c) - LVL_W'(pop);
        head_d   = head_q;
        if (pop) begin
            if (level_q > LVL_W'(1)) begin
                head_d = mem_q[rd_ptr_q + AW'(1)];
            end else if (do_push_c) begin
                head_d = push_data;
            end
        end else if (empty_c && do_push_c) begin
            head_d = push_data;
        end
        valid_d = (level_d != '0);
    end

    always_ff @(posedge clk) begin
        if (do_push_c) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            head_q   <= '0;
            valid_q  <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            head_q   <= head_d;
            valid_q  <= valid_d;
        end
    end

    assign data_out = head_q;
    assign valid    = valid_q;
    assign level    = level_q;

endmodule

// File: rtl/ft_fifo_reader.sv
// FT2232H async-FIFO read path: RXF# sync, timed RD# strobes, FWFT buffer, valid/ready stream.
// Define FT_READ_STATS_EN to add the 32-bit rd_count sample counter output.
module ft_fifo_reader
    import ft_pkg::*;
#(
    parameter int unsigned DATA_W         = 8,
    parameter int unsigned DEPTH          = 16,
    parameter int unsigned RD_LOW_CYCLES  = 4,
    parameter int unsigned RD_HIGH_CYCLES = 4,
    parameter int unsigned SYNC_STAGES    = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          rxf_n_in,
    input  logic [DATA_W-1:0]             d_in,
    output logic                          rd_n_out,
    output logic                          wr_n_out,
    output logic                          rxf_n_out,
    output logic [DATA_W-1:0]             m_data,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic [ft_level_w(DEPTH)-1:0]  fifo_level,
    output logic                          overflow
`ifdef FT_READ_STATS_EN
    ,
    output logic [31:0]                   rd_count
`endif
);

    localparam int unsigned LOW_N   = (RD_LOW_CYCLES  < FT_RD_LOW_MIN)  ? FT_RD_LOW_MIN  : RD_LOW_CYCLES;
    localparam int unsigned HIGH_N  = (RD_HIGH_CYCLES < FT_RD_HIGH_MIN) ? FT_RD_HIGH_MIN : RD_HIGH_CYCLES;
    localparam int unsigned SYNC_N  = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
    localparam int unsigned CNT_MAX = (LOW_N > HIGH_N) ? LOW_N : HIGH_N;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX);
    localparam logic [CNT_W-1:0] LOW_LAST  = CNT_W'(LOW_N - 1);
    localparam logic [CNT_W-1:0] HIGH_LAST = CNT_W'(HIGH_N - 1);

    logic [1:0]        rst_sync_q, rst_sync_d;
    logic              rst_ni;
    logic [SYNC_N-1:0] rxf_sync_q, rxf_sync_d;
    logic              rxf_sync;
    ft_state_e         state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              rd_n_q, rd_n_d;
    logic [DATA_W-1:0] sample_q, sample_d;
    logic              push_q, push_d;
    logic              overflow_q, overflow_d;
    logic              sample_fire_c;
    logic              fifo_full_c, fifo_empty_c, fifo_drop_c;

    // Async assert, sync release of the internal reset.
    assign rst_sync_d = {rst_sync_q[0], 1'b1};
    assign rst_ni     = rst_sync_q[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rst_sync_q <= '0;
        else        rst_sync_q <= rst_sync_d;
    end

    assign rxf_sync_d    = {rxf_sync_q[SYNC_N-2:0], rxf_n_in};
    assign rxf_sync      = rxf_sync_q[SYNC_N-1];
    assign sample_fire_c = (state_q == STROBE) && (cnt_q == LOW_LAST);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rd_n_d     = 1'b1;
        push_d     = 1'b0;
        sample_d   = sample_q;
        overflow_d = overflow_q | fifo_drop_c;
        case (state_q)
            IDLE: begin
                if (!rxf_sync && !fifo_full_c) begin
                    state_d = STROBE;
                    cnt_d   = '0;
                    rd_n_d  = 1'b0;
                end
            end
            STROBE: begin
                // Strobe always runs to completion, even if RXF# rises or the FIFO fills.
                if (sample_fire_c) begin
                    sample_d = d_in;
                    push_d   = 1'b1;
                    state_d  = HOLD;
                    cnt_d    = '0;
                end else begin
                    rd_n_d = 1'b0;
                    cnt_d  = cnt_q + CNT_W'(1);
                end
            end
            HOLD: begin
                // RXF# ignored here: it may still reflect the word just read.
                if (cnt_q == HIGH_LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            rxf_sync_q <= '1;
            state_q    <= IDLE;
            cnt_q      <= '0;
            rd_n_q     <= 1'b1;
            sample_q   <= '0;
            push_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            rxf_sync_q <= rxf_sync_d;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rd_n_q     <= rd_n_d;
            sample_q   <= sample_d;
            push_q     <= push_d;
            overflow_q <= overflow_d;
        end
    end

    ft_rx_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_ni),
        .push      (push_q),
        .push_data (sample_q),
        .pop       (m_ready && !fifo_empty_c),
        .data_out  (m_data),
        .valid     (m_valid),
        .level     (fifo_level),
        .full_c    (fifo_full_c),
        .empty_c   (fifo_empty_c),
        .drop_c    (fifo_drop_c)
    );

`ifdef FT_READ_STATS_EN
    logic [31:0] rd_count_q, rd_count_d;

    assign rd_count_d = rd_count_q + 32'(sample_fire_c);

    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) rd_count_q <= '0;
        else         rd_count_q <= rd_count_d;
    end

    assign rd_count = rd_count_q;
`endif

    assign rd_n_out  = rd_n_q;
    assign wr_n_out  = 1'b1;
    assign rxf_n_out = rxf_n_in;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_ft_fifo_reader.sv
// Bench for ft_fifo_reader: FTDI device model, in-order scoreboard, strobe timing monitor.
module tb_ft_fifo_reader;

    logic       clk;
    logic       rst_n;
    logic       rxf_n_in;
    logic [7:0] d_in;
    logic       rd_n_out;
    logic       wr_n_out;
    logic       rxf_n_out;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_ready;
    logic [4:0] fifo_level;
    logic       overflow;
`ifdef FT_READ_STATS_EN
    logic [31:0] rd_count;
`endif

    ft_fifo_reader dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rxf_n_in   (rxf_n_in),
        .d_in       (d_in),
        .rd_n_out   (rd_n_out),
        .wr_n_out   (wr_n_out),
        .rxf_n_out  (rxf_n_out),
        .m_data     (m_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .fifo_level (fifo_level),
        .overflow   (overflow)
`ifdef FT_READ_STATS_EN
        ,
        .rd_count   (rd_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] d;
        int         exp_low;
        int         exp_lat;
        logic [4:0] exp_lvl;
    } vec_t;

    int         total, bad;
    int         cyc, strobes, starts, low_run, high_run, last_low, last_high, rise_cyc, start_cyc;
    logic       prev_rd;
    bit         manual;
    logic [7:0] dev_q[$];
    logic [7:0] exp_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock: scoreboard on the handshake about to happen, then monitor and device update.
    task automatic step();
        if (m_valid && m_ready) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL sb_extra actual=%0h expected=none (cycle %0d)", m_data, cyc);
            end else begin
                chk("sb_data", 64'(m_data), 64'(exp_q.pop_front()));
            end
        end
        @(negedge clk);
        cyc++;
        if (!rd_n_out) begin
            if (prev_rd) begin
                last_high = high_run;
                high_run  = 0;
                starts++;
                start_cyc = cyc;
            end
            low_run++;
        end else begin
            if (!prev_rd) begin
                last_low = low_run;
                low_run  = 0;
                strobes++;
                rise_cyc = cyc;
                if (!manual && dev_q.size() != 0) void'(dev_q.pop_front());
            end
            high_run++;
        end
        prev_rd = rd_n_out;
        if (!manual) begin
            rxf_n_in = (dev_q.size() == 0);
            d_in     = (dev_q.size() != 0) ? dev_q[0] : 8'h00;
        end
    endtask

    initial begin
        vec_t vecs[4];
        int   s0, st0, first;
        bit   got;

        vecs[0] = '{8'hA5, 4, 1, 5'd1};
        vecs[1] = '{8'h00, 4, 1, 5'd1};
        vecs[2] = '{8'hFF, 4, 1, 5'd1};
        vecs[3] = '{8'h3C, 4, 1, 5'd1};

        total = 0; bad = 0; cyc = 0; strobes = 0; starts = 0;
        low_run = 0; high_run = 0; last_low = 0; last_high = 0;
        rise_cyc = 0; start_cyc = 0; prev_rd = 1'b1; manual = 1'b0;
        rst_n = 1'b0; rxf_n_in = 1'b1; d_in = 8'h00; m_ready = 1'b0;

        repeat (3) @(negedge clk);
        chk("rst_rd_n", 64'(rd_n_out), 64'(1));
        chk("rst_wr_n", 64'(wr_n_out), 64'(1));
        chk("rst_valid", 64'(m_valid), 64'(0));
        chk("rst_data", 64'(m_data), 64'(0));
        chk("rst_level", 64'(fifo_level), 64'(0));
        chk("rst_ovf", 64'(overflow), 64'(0));
        rst_n = 1'b1;
        repeat (4) step();
        chk("rxf_pass_hi", 64'(rxf_n_out), 64'(rxf_n_in));

        // Single-word reads from the vector table
        foreach (vecs[i]) begin
            s0 = strobes;
            dev_q.push_back(vecs[i].d);
            exp_q.push_back(vecs[i].d);
            step();
            got = 1'b0;
            for (int k = 0; k < 60 && !got; k++) begin
                step();
                if (m_valid) got = 1'b1;
            end
            chk("single_wait", 64'(got), 64'(1));
            chk("single_strobes", 64'(strobes), 64'(s0 + 1));
            chk("single_low", 64'(last_low), 64'(vecs[i].exp_low));
            chk("single_lat", 64'(cyc - rise_cyc), 64'(vecs[i].exp_lat));
            chk("single_data", 64'(m_data), 64'(vecs[i].d));
            chk("single_level", 64'(fifo_level), 64'(vecs[i].exp_lvl));
            m_ready = 1'b1;
            step();
            m_ready = 1'b0;
            step();
            chk("single_drain_lvl", 64'(fifo_level), 64'(0));
            chk("single_drain_vld", 64'(m_valid), 64'(0));
            chk("single_hold_data", 64'(m_data), 64'(vecs[i].d));
            repeat (12) step();
            chk("single_no_extra", 64'(strobes), 64'(s0 + 1));
        end

        // Burst of 32 with m_ready held high
        m_ready = 1'b1;
        s0 = strobes; st0 = starts; first = -1;
        for (int i = 0; i < 32; i++) begin
            dev_q.push_back(8'(i));
            exp_q.push_back(8'(i));
        end
        for (int k = 0; k < 600 && exp_q.size() != 0; k++) begin
            step();
            if (starts == st0 + 1 && first < 0) first = start_cyc;
        end
        chk("burst_drained", 64'(exp_q.size()), 64'(0));
        chk("burst_strobes", 64'(strobes), 64'(s0 + 32));
        chk("burst_low", 64'(last_low), 64'(4));
        chk("burst_high", 64'(last_high), 64'(5));
        chk("burst_period", 64'(start_cyc - first), 64'(31 * 9));
        chk("burst_ovf", 64'(overflow), 64'(0));
        m_ready = 1'b0;
        repeat (5) step();

        // Backpressure: 20 pending, only 16 fit
        s0 = strobes;
        for (int i = 0; i < 20; i++) begin
            dev_q.push_back(8'(8'h40 + i));
            exp_q.push_back(8'(8'h40 + i));
        end
        repeat (250) step();
        chk("bp_strobes", 64'(strobes), 64'(s0 + 16));
        chk("bp_level", 64'(fifo_level), 64'(16));
        chk("bp_rd_n", 64'(rd_n_out), 64'(1));
        chk("bp_ovf", 64'(overflow), 64'(0));
        chk("bp_valid", 64'(m_valid), 64'(1));
        chk("bp_head", 64'(m_data), 64'(8'h40));
        repeat (30) step();
        chk("bp_stalled", 64'(strobes), 64'(s0 + 16));
        m_ready = 1'b1;
        for (int k = 0; k < 400 && exp_q.size() != 0; k++) step();
        chk("bp_drained", 64'(exp_q.size()), 64'(0));
        chk("bp_strobes_all", 64'(strobes), 64'(s0 + 20));
        repeat (5) step();
        chk("bp_level_end", 64'(fifo_level), 64'(0));
        chk("bp_ovf_end", 64'(overflow), 64'(0));
        m_ready = 1'b0;
        repeat (5) step();

        // Stale RXF#: one word, RXF# deasserts one cycle after RD# rises
        manual = 1'b1;
        s0 = strobes;
        rxf_n_in = 1'b0;
        d_in = 8'h5A;
        exp_q.push_back(8'h5A);
        got = 1'b0;
        for (int k = 0; k < 40 && !got; k++) begin
            step();
            if (strobes == s0 + 1) got = 1'b1;
        end
        chk("stale_wait", 64'(got), 64'(1));
        step();
        rxf_n_in = 1'b1;
        repeat (20) step();
        chk("stale_one_strobe", 64'(strobes), 64'(s0 + 1));
        chk("stale_low", 64'(last_low), 64'(4));
        chk("stale_rd_n", 64'(rd_n_out), 64'(1));
        chk("stale_level", 64'(fifo_level), 64'(1));
        chk("stale_data", 64'(m_data), 64'(8'h5A));
        chk("rxf_pass_stale", 64'(rxf_n_out), 64'(rxf_n_in));

        // Reset during the second low cycle of a strobe (FIFO still holds 0x5A)
        rxf_n_in = 1'b0;
        d_in = 8'h77;
        got = 1'b0;
        for (int k = 0; k < 30 && !got; k++) begin
            step();
            if (!rd_n_out) got = 1'b1;
        end
        chk("rst_mid_wait", 64'(got), 64'(1));
        chk("rxf_pass_lo", 64'(rxf_n_out), 64'(rxf_n_in));
        step();
        chk("rst_mid_low2", 64'(rd_n_out), 64'(0));
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        chk("rst_mid_rd_n", 64'(rd_n_out), 64'(1));
        chk("rst_mid_level", 64'(fifo_level), 64'(0));
        chk("rst_mid_valid", 64'(m_valid), 64'(0));
        step();
        step();
        rst_n = 1'b1;
        exp_q.push_back(8'h77);
        got = 1'b0;
        for (int k = 0; k < 30 && !got; k++) begin
            step();
            if (!rd_n_out) got = 1'b1;
        end
        chk("rst_fresh_start", 64'(got), 64'(1));
        got = 1'b0;
        for (int k = 0; k < 30 && !got; k++) begin
            step();
            if (rd_n_out) got = 1'b1;
        end
        chk("rst_fresh_end", 64'(got), 64'(1));
        chk("rst_fresh_low", 64'(last_low), 64'(4));
        rxf_n_in = 1'b1;
        repeat (4) step();
        chk("rst_fresh_level", 64'(fifo_level), 64'(1));
        chk("rst_fresh_data", 64'(m_data), 64'(8'h77));
        m_ready = 1'b1;
        step();
        step();
        m_ready = 1'b0;
        chk("rst_fresh_sb", 64'(exp_q.size()), 64'(0));
        chk("rst_fresh_drain", 64'(fifo_level), 64'(0));
        manual = 1'b0;
        repeat (10) step();

`ifdef FT_READ_STATS_EN
        rst_n = 1'b0;
        exp_q.delete();
        dev_q.delete();
        step();
        step();
        chk("stats_rst", 64'(rd_count), 64'(0));
        rst_n = 1'b1;
        repeat (4) step();
        m_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            dev_q.push_back(8'(8'hC0 + i));
            exp_q.push_back(8'(8'hC0 + i));
        end
        for (int k = 0; k < 200 && exp_q.size() != 0; k++) step();
        repeat (10) step();
        chk("stats_drained", 64'(exp_q.size()), 64'(0));
        chk("stats_count", 64'(rd_count), 64'(5));
        rst_n = 1'b0;
        #1;
        chk("stats_clear", 64'(rd_count), 64'(0));
        step();
        rst_n = 1'b1;
        m_ready = 1'b0;
        repeat (4) step();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
